conv_tap_sequencer: RTL

Loop-nest controller for a single-MAC convolution engine: iterates output position, output channel and kernel taps (in_ch, ky, kx), and issues one tap per cycle.
- Per tap it drives the feature-RAM read address and channel select, plus the weight-ROM address.
- It also drives the MAC control strobes (clear/accumulate/last) and the bias index, delayed to match memory latency.
- At the end of each output position it holds, via a valid/ack handshake, until downstream quantise/pool logic drains the per-position channel buffer.
- Sits between the feature/weight memories and the accumulator/output buffer of the CONV2 layer.

---
 rtl/conv_seq_pkg.sv | 41 ++++
 rtl/conv_strobe_pipe.sv | 26 ++
 rtl/conv_tap_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/conv_seq_pkg.sv
// Shared types and CONV2 dimension constants for the convolution tap sequencer.
package conv_seq_pkg;

  localparam int unsigned CONV2_IN_W   = 12;
  localparam int unsigned CONV2_IN_CH  = 6;
  localparam int unsigned CONV2_OUT_CH = 16;
  localparam int unsigned CONV2_K      = 5;

  localparam int unsigned FEAT_AW = 8;
  localparam int unsigned W_AW    = 12;
  localparam int unsigned CH_W    = 3;
  localparam int unsigned OC_W    = 4;
  localparam int unsigned POS_W   = 3;
  localparam int unsigned TAP_W   = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic            valid;
    logic            first;
    logic            last;
    logic [OC_W-1:0] oc;
  } strobe_t;

  // Constant multiply unrolled into shifted adds of the set bits of c.
  function automatic logic [FEAT_AW-1:0] row_times_width(input logic [TAP_W:0] r,
                                                         input int unsigned c);
    logic [FEAT_AW-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < FEAT_AW; i++)
      if (c[i]) acc = acc + (FEAT_AW'(r) << i);
    return acc;
  endfunction

endpackage

// File: rtl/conv_strobe_pipe.sv
// MEM_LAT-deep delay line aligning MAC strobes with feature/weight memory data.
module conv_strobe_pipe
  import conv_seq_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  strobe_t d,
  output strobe_t q
);

  strobe_t stage [MEM_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MEM_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < MEM_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[MEM_LAT-1];

endmodule

// File: rtl/conv_tap_sequencer.sv
// Loop-nest controller for the CONV2 single-MAC engine (kx, ky, k_ch, oc per position).
// Optional stall counter output enabled by CONV_TAP_SEQ_PERF_EN.
module conv_tap_sequencer
  import conv_seq_pkg::*;
#(
  parameter int unsigned IN_W    = CONV2_IN_W,
  parameter int unsigned IN_CH   = CONV2_IN_CH,
  parameter int unsigned OUT_CH  = CONV2_OUT_CH,
  parameter int unsigned K       = CONV2_K,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [FEAT_AW-1:0] feat_rd_addr,
  output logic [CH_W-1:0]    feat_ch,
  output logic [W_AW-1:0]    w_addr,
  output logic               mac_en,
  output logic               acc_clr,
  output logic               acc_last,
  output logic [OC_W-1:0]    mac_oc,
  output logic               pos_valid,
  output logic [POS_W-1:0]   pos_x,
  output logic [POS_W-1:0]   pos_y,
  input  logic               pos_ack,
  output logic               busy,
`ifdef CONV_TAP_SEQ_PERF_EN
  output logic               done,
  output logic [31:0]        stall_cycles
`else
  output logic               done
`endif
);

  localparam int unsigned OUT_W = IN_W - K + 1;

  if (OUT_W > (1 << POS_W)) begin : g_chk_pos
    $fatal(1, "pos_x/pos_y too narrow for OUT_W");
  end
  if (K > (1 << TAP_W)) begin : g_chk_k
    $fatal(1, "kx/ky too narrow for K");
  end
  if (IN_CH > (1 << CH_W)) begin : g_chk_ch
    $fatal(1, "feat_ch too narrow for IN_CH");
  end
  if (OUT_CH > (1 << OC_W)) begin : g_chk_oc
    $fatal(1, "mac_oc too narrow for OUT_CH");
  end
  if (IN_W * IN_W > (1 << FEAT_AW)) begin : g_chk_feat
    $fatal(1, "feat_rd_addr too narrow for IN_W");
  end
  if (OUT_CH * IN_CH * K * K > (1 << W_AW)) begin : g_chk_w
    $fatal(1, "w_addr too narrow for weight count");
  end
  if (MEM_LAT < 1 || MEM_LAT > 3) begin : g_chk_lat
    $fatal(1, "MEM_LAT must be 1..3");
  end

  localparam logic [TAP_W-1:0] K_MAX   = TAP_W'(K - 1);
  localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(IN_CH - 1);
  localparam logic [OC_W-1:0]  OC_MAX  = OC_W'(OUT_CH - 1);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(OUT_W - 1);
  localparam logic [1:0]       FL_MAX  = 2'(MEM_LAT - 1);

  seq_state_e        state;
  logic [TAP_W-1:0]  kx, ky;
  logic [CH_W-1:0]   k_ch;
  logic [OC_W-1:0]   oc;
  logic [W_AW-1:0]   w_cnt;
  logic [1:0]        fl_cnt;
  logic              tap_last, final_tap, final_pos;
  logic [TAP_W:0]    row, col;
  strobe_t           stb_d, stb_q;

  assign tap_last  = (kx == K_MAX) && (ky == K_MAX) && (k_ch == CH_MAX);
  assign final_tap = tap_last && (oc == OC_MAX);
  assign final_pos = (pos_x == POS_MAX) && (pos_y == POS_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      kx     <= '0;
      ky     <= '0;
      k_ch   <= '0;
      oc     <= '0;
      w_cnt  <= '0;
      fl_cnt <= '0;
      pos_x  <= '0;
      pos_y  <= '0;
    end else begin
      case (state)
        IDLE: if (start) state <= RUN;
        RUN: begin
          // Counters freeze on the final tap so addresses stay held through FLUSH/DRAIN.
          if (final_tap) begin
            state  <= FLUSH;
            fl_cnt <= '0;
          end else begin
            w_cnt <= w_cnt + 1'b1;
            if (kx != K_MAX) kx <= kx + 1'b1;
            else begin
              kx <= '0;
              if (ky != K_MAX) ky <= ky + 1'b1;
              else begin
                ky <= '0;
                if (k_ch != CH_MAX) k_ch <= k_ch + 1'b1;
                else begin
                  k_ch <= '0;
                  oc   <= oc + 1'b1;
                end
              end
            end
          end
        end
        FLUSH: begin
          if (fl_cnt == FL_MAX) state <= DRAIN;
          else fl_cnt <= fl_cnt + 1'b1;
        end
        DRAIN: begin
          if (pos_ack) begin
            kx    <= '0;
            ky    <= '0;
            k_ch  <= '0;
            oc    <= '0;
            w_cnt <= '0;
            if (final_pos) begin
              pos_x <= '0;
              pos_y <= '0;
              state <= DONE;
            end else begin
              state <= RUN;
              if (pos_x != POS_MAX) pos_x <= pos_x + 1'b1;
              else begin
                pos_x <= '0;
                pos_y <= pos_y + 1'b1;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign row          = {1'b0, pos_y} + {1'b0, ky};
  assign col          = {1'b0, pos_x} + {1'b0, kx};
  assign feat_rd_addr = row_times_width(row, IN_W) + FEAT_AW'(col);
  assign feat_ch      = k_ch;
  assign w_addr       = w_cnt;

  always_comb begin
    stb_d       = '0;
    stb_d.valid = (state == RUN);
    stb_d.first = (state == RUN) && (kx == '0) && (ky == '0) && (k_ch == '0);
    stb_d.last  = (state == RUN) && tap_last;
    stb_d.oc    = oc;
  end

  conv_strobe_pipe #(.MEM_LAT(MEM_LAT)) u_strobe_pipe (
    .clk (clk),
    .rst (rst),
    .d   (stb_d),
    .q   (stb_q)
  );

  assign mac_en    = stb_q.valid;
  assign acc_clr   = stb_q.first;
  assign acc_last  = stb_q.last;
  assign mac_oc    = stb_q.oc;
  assign pos_valid = (state == DRAIN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

`ifdef CONV_TAP_SEQ_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else if (state == IDLE && start) stall_q <= '0;
    else if (state == DRAIN && !pos_ack && stall_q != '1) stall_q <= stall_q + 1'b1;
  end

  assign stall_cycles = stall_q;
`endif

endmodule
